// File: rtl/rvv_pkg.sv
// Shared vector-unit definitions for the writeback path.
// Holds register geometry, SEW encodings, the tail-policy enum and the
// elements-per-register helper used by the merge logic and the stage queue.
package rvv_pkg;

  localparam int VLEN  = 128;
  localparam int VLENB = VLEN / 8;
  localparam int VL_W  = 9;

  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] SEW_64 = 3'b011;

  typedef enum logic {
    TAIL_UNDIST   = 1'b0,
    TAIL_AGNOSTIC = 1'b1
  } tail_pol_e;

  // One pending register-file write.
  typedef struct packed {
    logic [4:0]      wa;
    logic [VLEN-1:0] wd;
  } wb_ent_t;

  // Elements per register for a legal SEW code: 16, 8, 4 or 2.
  function automatic logic [4:0] epr(input logic [2:0] sew);
    return 5'(32'd16 >> sew[1:0]);
  endfunction

  function automatic logic sew_legal(input logic [2:0] sew);
    return (sew[2] == 1'b0);
  endfunction

endpackage

// File: rtl/vwb_merge.sv
// Byte-granular merge of an ALU result with the old destination register.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: res/old data in, vta tail policy, sew code, vl, uop_idx within the
//        LMUL group; wd merged data out, sew_ok high for a legal SEW code.
module vwb_merge
  import rvv_pkg::*;
(
  input  logic [VLEN-1:0] res,
  input  logic [VLEN-1:0] old,
  input  logic            vta,
  input  logic [2:0]      sew,
  input  logic [VL_W-1:0] vl,
  input  logic [2:0]      uop_idx,
  output logic [VLEN-1:0] wd,
  output logic            sew_ok
);

  logic [4:0] epr_w;
  tail_pol_e  pol;

  assign epr_w  = epr(sew);
  assign sew_ok = sew_legal(sew);
  assign pol    = tail_pol_e'(vta);

  genvar b;
  generate
    for (b = 0; b < VLENB; b++) begin : g_byte
      logic [3:0]    elem;
      logic [VL_W:0] e_idx;
      logic          active;
      logic [7:0]    tail_byte;

      // Element number inside this register that owns byte b.
      assign elem = 4'(b) >> sew[1:0];
      // Global element index; one bit wider than vl so the compare never wraps.
      assign e_idx = (VL_W + 1)'(uop_idx) * (VL_W + 1)'(epr_w) + (VL_W + 1)'(elem);
      assign active = (e_idx < {1'b0, vl});
      assign tail_byte = (pol == TAIL_AGNOSTIC) ? 8'hFF : old[8*b +: 8];

      // An illegal SEW leaves the register untouched whatever the tail policy.
      assign wd[8*b +: 8] = !sew_ok ? old[8*b +: 8] :
                            active  ? res[8*b +: 8] : tail_byte;
    end
  endgenerate

endmodule

// File: rtl/vwb_stage.sv
// Vector writeback stage: merge ALU result with old vd, queue, write to VRF.
// Latency: accept at edge N is on wb_* in cycle N+1 when the queue is empty.
// Backpressure: 2-entry queue; in_ready drops when full, head held while !wb_ready.
// Ports: clk/rst (sync, active-low); in_* ALU result + merge controls with
//        valid/ready; wb_* register-file write with valid/ready and wb_wen;
//        err_seq / err_sew one-cycle error pulses.
module vwb_stage
  import rvv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_wa,
  input  logic [VLEN-1:0] in_res,
  input  logic [VLEN-1:0] in_old,
  input  logic [2:0]      in_sew,
  input  logic [VL_W-1:0] in_vl,
  input  logic [2:0]      in_uop_idx,
  input  logic            in_vta,
  input  logic            in_last,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_wa,
  output logic [VLEN-1:0] wb_wd,
  output logic            wb_wen,
  output logic            err_seq,
  output logic            err_sew
);

  logic [1:0] count_q, count_d;
  wb_ent_t    ent0_q, ent0_d;  // queue head
  wb_ent_t    ent1_q, ent1_d;
  logic [2:0] exp_idx_q, exp_idx_d;
  logic       err_seq_q, err_seq_d;
  logic       err_sew_q, err_sew_d;

  logic [VLEN-1:0] merged_wd;
  logic            sew_ok;
  wb_ent_t         new_ent;
  logic            push, pop;

  vwb_merge u_merge (
    .res     (in_res),
    .old     (in_old),
    .vta     (in_vta),
    .sew     (in_sew),
    .vl      (in_vl),
    .uop_idx (in_uop_idx),
    .wd      (merged_wd),
    .sew_ok  (sew_ok)
  );

  // Gating with rst keeps the handshakes dead during the reset cycle itself.
  assign in_ready = rst & (count_q < 2'd2);
  assign wb_valid = rst & (count_q != 2'd0);
  assign wb_wen   = wb_valid & wb_ready;
  assign wb_wa    = ent0_q.wa;
  assign wb_wd    = ent0_q.wd;
  assign err_seq  = err_seq_q;
  assign err_sew  = err_sew_q;

  assign push    = in_valid & in_ready;
  assign pop     = wb_valid & wb_ready;
  assign new_ent = '{wa: in_wa, wd: merged_wd};

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (pop) begin
      // Shift only when a second entry exists; an emptied head may keep stale data.
      if (count_q == 2'd2) begin
        ent0_d = ent1_q;
      end
      count_d = count_d - 2'd1;
    end
    if (push) begin
      // count_d is now the post-pop occupancy, i.e. the free slot index.
      if (count_d == 2'd0) begin
        ent0_d = new_ent;
      end else begin
        ent1_d = new_ent;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_comb begin
    exp_idx_d = exp_idx_q;
    err_seq_d = 1'b0;
    err_sew_d = 1'b0;
    if (push) begin
      err_seq_d = (in_uop_idx != exp_idx_q);
      err_sew_d = !sew_ok;
      // Resync to whatever arrived so a single gap raises a single pulse.
      exp_idx_d = in_last ? 3'd0 : in_uop_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 2'd0;
      ent0_q    <= '0;
      ent1_q    <= '0;
      exp_idx_q <= 3'd0;
      err_seq_q <= 1'b0;
      err_sew_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      exp_idx_q <= exp_idx_d;
      err_seq_q <= err_seq_d;
      err_sew_q <= err_sew_d;
    end
  end

endmodule

// File: doc/vwb_stage.md
# vwb_stage

Vector writeback stage sitting directly downstream of the vector ALU and its ID/EX register, feeding the vector register file write port. It takes one 128-bit ALU result per micro-op and merges it with the old destination contents, using vl, SEW, the micro-op's position in an LMUL register group and the tail policy. Merged results are buffered in a 2-entry queue and presented to the register file with a valid/ready handshake. The stage also checks the micro-op sequence within each LMUL group and flags illegal SEW encodings.

## Interface
- VLEN, 128, vector register width in bits
- VL_W, 9, width of vl
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low; clock clk
- in_valid  in  1  ALU result available
- in_ready  out  1  stage can accept a result
- in_wa  in  5  destination vector register
- in_res  in  VLEN  ALU result
- in_old  in  VLEN  current destination register contents
- in_sew  in  3  encoded SEW: 000=8, 001=16, 010=32, 011=64, others illegal
- in_vl  in  VL_W  active vector length, counted in elements
- in_uop_idx  in  3  register index within the LMUL group
- in_vta  in  1  tail policy: 0 = undisturbed, 1 = agnostic (all ones)
- in_last  in  1  last micro-op of the group
- wb_valid  out  1  write pending at the queue head
- wb_ready  in  1  register file accepts the write
- wb_wa  out  5  write address
- wb_wd  out  VLEN  merged write data
- wb_wen  out  1  wb_valid & wb_ready
- err_seq  out  1  one-cycle pulse: out-of-order uop_idx
- err_sew  out  1  one-cycle pulse: illegal SEW accepted

## Operation
- Accept when in_valid & in_ready. Merge is combinational at the input and the result is stored in the queue.
- Elements per register: EPR = 16 >> in_sew (16, 8, 4 or 2).
- For element i in 0..EPR-1, the global index is e = in_uop_idx*EPR + i.
  - If e < in_vl, the element's bytes come from in_res.
  - Otherwise the element is tail: its bytes come from in_old when in_vta=0, or are 0xFF when in_vta=1.
- Compare e against in_vl at full width; e never truncates.
- in_vl = 0: every element is tail.
- Illegal in_sew: write wd = in_old unchanged (regardless of in_vta) and pulse err_sew the cycle after acceptance.
- Sequence checker:
  - exp_idx is 3 bits, reset to 0.
  - On accept, if in_uop_idx != exp_idx, pulse err_seq the next cycle.
  - Then set exp_idx to 0 if in_last, otherwise to in_uop_idx + 1 (mod 8). The next index resyncs to the stream.
  - The erroneous entry is still queued and written.
- Queue: 2 entries, FIFO order, count 0..2.
  - in_ready = rst & (count < 2).
  - Pop on wb_valid & wb_ready.
  - Push and pop in the same cycle at count 1 leaves count at 1.
  - Push is impossible at count 2.

## Timing
- Latency: accept at edge N makes the entry visible on wb_* after edge N (cycle N+1) if the queue was empty.
- Throughput: 1 result/cycle while wb_ready=1.
- wb_wa and wb_wd are held stable while wb_valid=1 and wb_ready=0.
- Reset values (also when rst is sampled low mid-operation):
  - count, exp_idx: 0
  - wb_valid, wb_wen, err_seq, err_sew: 0
  - wb_wa: 0
  - wb_wd: 0
  - in_ready: 0 while rst is low
- Queued entries are discarded on reset; no write occurs in the reset cycle.
- err_seq and err_sew are registered pulses, exactly one cycle wide per offending accept.

## Structure
- rvv_pkg holds:
  - VLEN
  - SEW code constants
  - an EPR function
  - a tail-policy enum
- Sub-module vwb_merge: purely combinational byte-mask generation and merge (res/old/vta/sew/vl/uop_idx → wd, sew_ok).
- The top holds the queue, the sequence checker and the error registers.

## Test plan
- SEW=32 (010), vl=3, uop 0, vta=0, res all 0xAA, old all 0x11, wb_ready=1 → next cycle wb_valid=1; wd bytes 0–11 = 0xAA, bytes 12–15 = 0x11; wb_wen=1.
- SEW=8, vl=20, uop 1, vta=1, res all 0x55 → wd bytes 0–3 = 0x55, bytes 4–15 = 0xFF.
- wb_ready=0, push 3 results (wa 1, 2, 3) → in_ready drops after the 2nd accept. Release wb_ready → writes to wa 1, 2, 3 in order on consecutive cycles.
- Uops 0, 1, 3 (3 with in_last) → single err_seq pulse one cycle after the third accept. Next group starting at 0 → no error.
- in_sew=101, vta=1 → err_sew pulses once; wd = in_old.
- Queue holding 2 entries, rst low for 1 cycle → wb_valid=0, in_ready=0 during reset, in_ready=1 after. The next group starting at uop 0 raises no err_seq.
